// File: rtl/dram_port_arbiter.sv
// Two-way arbiter for the shared synchronous-read DRAM: the CPU MEM stage has fixed priority.
// The debug/loader port is guaranteed a slot by a starvation counter and can lock the DRAM for exclusive use.
module dram_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic [3:0]        dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_spo
);

  typedef enum logic [1:0] {CPU_PRI, DBG_SLOT, LOCKED} state_t;

  localparam logic [7:0] STARVE_LAST = 8'(STARVE_MAX - 1);

  state_t     state, state_next, grant_state;
  logic [7:0] starve_cnt, starve_cnt_next;
  logic       cpu_gnt, dbg_gnt, dbg_denied, dbg_rd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= CPU_PRI;
      starve_cnt <= 8'd0;
      dbg_rd_q   <= 1'b0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
      dbg_rd_q   <= dbg_gnt && (dbg_we == 4'b0000);
    end
  end

  assign dbg_denied = (state == CPU_PRI) && cpu_req && dbg_valid;

  // The counter only survives a cycle in which CPU_PRI is kept and debug is denied again.
  always_comb begin
    state_next      = state;
    starve_cnt_next = 8'd0;
    if (dbg_lock) begin
      state_next = LOCKED;
    end else begin
      unique case (state)
        LOCKED:   state_next = CPU_PRI;
        DBG_SLOT: state_next = CPU_PRI;
        default: begin
          if (dbg_denied) begin
            if (starve_cnt == STARVE_LAST) state_next = DBG_SLOT;
            else                           starve_cnt_next = starve_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  // While reset is held, grants follow CPU_PRI rules so that a write issued in that cycle still commits.
  assign grant_state = rst_n ? state : CPU_PRI;

  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    unique case (grant_state)
      LOCKED: dbg_gnt = dbg_valid;
      DBG_SLOT: begin
        dbg_gnt = dbg_valid;
        cpu_gnt = cpu_req && !dbg_valid;
      end
      default: begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_valid && !cpu_req;
      end
    endcase

    mem_a   = cpu_addr;
    mem_we  = 4'b0000;
    mem_din = cpu_wdata;
    if (dbg_gnt) begin
      mem_a   = dbg_addr;
      mem_we  = dbg_we;
      mem_din = dbg_wdata;
    end else if (cpu_gnt) begin
      mem_we  = cpu_we;
    end
  end

  assign cpu_stall  = cpu_req && !cpu_gnt;
  assign dbg_ready  = dbg_gnt;
  assign dbg_rvalid = dbg_rd_q;
  assign cpu_rdata  = mem_spo;
  assign dbg_rdata  = mem_spo;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Testbench for dram_port_arbiter: directed scenarios followed by random traffic.
// A behavioural model fills a scoreboard that an independent monitor drains.
module tb_dram_port_arbiter;

  localparam int AW         = 16;
  localparam int STARVE_MAX = 4;

  typedef struct {
    logic          rst_n;
    logic          cpu_req;
    logic [3:0]    cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          dbg_valid;
    logic [3:0]    dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic          dbg_lock;
  } stim_t;

  typedef struct {
    logic          stall;
    logic          ready;
    logic          rvalid;
    logic [AW-1:0] a;
    logic [3:0]    we;
    logic [31:0]   din;
    logic          cpu_rd_chk;
    logic [31:0]   cpu_rd;
  } exp_t;

  typedef enum {M_NORMAL, M_SLOT, M_LOCKED} mmode_t;

  logic          clk, rst_n;
  logic          cpu_req, cpu_stall, dbg_valid, dbg_ready, dbg_lock, dbg_rvalid;
  logic [3:0]    cpu_we, dbg_we, mem_we;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_a;
  logic [31:0]   cpu_wdata, cpu_rdata, dbg_wdata, dbg_rdata, mem_din, mem_spo;

  logic [31:0] dram    [0:65535];
  logic [31:0] ref_mem [0:65535];

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];

  int checks = 0;
  int fails  = 0;

  mmode_t      m_mode = M_NORMAL;
  int          m_wait = 0;
  logic        m_dbg_rd_pending = 1'b0;
  logic        m_cpu_rd_pending = 1'b0;
  logic [31:0] m_cpu_rd_data = 32'h0;
  logic        m_dbg_waiting = 1'b0;
  stim_t       m_last;

  dram_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_a(mem_a), .mem_we(mem_we), .mem_din(mem_din), .mem_spo(mem_spo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side DRAM: registered read of the old word, byte-lane writes.
  always @(posedge clk) begin
    logic [31:0] w;
    w = dram[mem_a];
    mem_spo <= w;
    for (int i = 0; i < 4; i++) if (mem_we[i]) w[8*i +: 8] = mem_din[8*i +: 8];
    if (mem_we != 4'b0000) dram[mem_a] <= w;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1; s.cpu_req = 1'b0; s.cpu_we = 4'h0; s.cpu_addr = '0; s.cpu_wdata = 32'h0;
    s.dbg_valid = 1'b0; s.dbg_we = 4'h0; s.dbg_addr = '0; s.dbg_wdata = 32'h0; s.dbg_lock = 1'b0;
    return s;
  endfunction

  // Drives one cycle and predicts its outcome from the arbitration rules.
  task automatic applyStimulus(input stim_t s);
    exp_t   e;
    mmode_t eff;
    logic   cg, dg, denied;
    @(posedge clk);
    #1;
    rst_n = s.rst_n; cpu_req = s.cpu_req; cpu_we = s.cpu_we; cpu_addr = s.cpu_addr;
    cpu_wdata = s.cpu_wdata; dbg_valid = s.dbg_valid; dbg_we = s.dbg_we; dbg_addr = s.dbg_addr;
    dbg_wdata = s.dbg_wdata; dbg_lock = s.dbg_lock;

    eff = s.rst_n ? m_mode : M_NORMAL;
    if (eff == M_LOCKED) begin
      dg = s.dbg_valid; cg = 1'b0;
    end else if (eff == M_SLOT && s.dbg_valid) begin
      dg = 1'b1; cg = 1'b0;
    end else begin
      cg = s.cpu_req; dg = s.dbg_valid && !s.cpu_req;
    end

    e.stall = s.cpu_req && !cg;
    e.ready = dg;
    e.rvalid = m_dbg_rd_pending;
    e.cpu_rd_chk = m_cpu_rd_pending;
    e.cpu_rd = m_cpu_rd_data;
    if (dg) begin
      e.a = s.dbg_addr; e.we = s.dbg_we; e.din = s.dbg_wdata;
    end else begin
      e.a = s.cpu_addr; e.we = cg ? s.cpu_we : 4'h0; e.din = s.cpu_wdata;
    end
    exp_q.push_back(e);

    m_cpu_rd_pending = cg && (s.cpu_we == 4'h0);
    m_cpu_rd_data    = ref_mem[s.cpu_addr];
    m_dbg_rd_pending = s.rst_n && dg && (s.dbg_we == 4'h0);
    if (m_dbg_rd_pending) rd_q.push_back(ref_mem[s.dbg_addr]);
    for (int i = 0; i < 4; i++) if (e.we[i]) ref_mem[e.a][8*i +: 8] = e.din[8*i +: 8];

    denied = (eff == M_NORMAL) && s.cpu_req && s.dbg_valid;
    if (!s.rst_n) begin
      m_mode = M_NORMAL; m_wait = 0;
    end else if (s.dbg_lock) begin
      m_mode = M_LOCKED; m_wait = 0;
    end else if (m_mode != M_NORMAL) begin
      m_mode = M_NORMAL; m_wait = 0;
    end else if (denied) begin
      m_wait++;
      if (m_wait >= STARVE_MAX) begin
        m_mode = M_SLOT; m_wait = 0;
      end
    end else begin
      m_wait = 0;
    end
    m_dbg_waiting = s.dbg_valid && !dg;
    m_last = s;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] rd;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput("cpu_stall", {31'b0, cpu_stall}, {31'b0, e.stall});
      checkOutput("dbg_ready", {31'b0, dbg_ready}, {31'b0, e.ready});
      checkOutput("dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, e.rvalid});
      checkOutput("mem_a", {16'b0, mem_a}, {16'b0, e.a});
      checkOutput("mem_we", {28'b0, mem_we}, {28'b0, e.we});
      checkOutput("mem_din", mem_din, e.din);
      if (e.cpu_rd_chk) checkOutput("cpu_rdata", cpu_rdata, e.cpu_rd);
    end
    if (dbg_rvalid === 1'b1) begin
      if (rd_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL dbg_rdata: got rvalid with data 0x%08h, expected no read pending", dbg_rdata);
      end else begin
        rd = rd_q.pop_front();
        checkOutput("dbg_rdata", dbg_rdata, rd);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    stim_t s;
    int    lock_left;
    for (int i = 0; i < 65536; i++) begin
      dram[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    dram[16'h0010] = 32'hDEADBEEF;
    ref_mem[16'h0010] = 32'hDEADBEEF;
    s = idle();
    s.rst_n = 1'b0;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_wdata = 32'h0;
    dbg_valid = 1'b0; dbg_we = 4'h0; dbg_addr = '0; dbg_wdata = 32'h0; dbg_lock = 1'b0;

    applyStimulus(s);
    applyStimulus(s);
    @(negedge clk);
    checkOutput("reset_stall", {31'b0, cpu_stall}, 32'd0);
    checkOutput("reset_rvalid", {31'b0, dbg_rvalid}, 32'd0);

    s = idle(); s.cpu_req = 1'b1; s.cpu_addr = 16'h0010;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("cpu_only_stall", {31'b0, cpu_stall}, 32'd0);
    checkOutput("cpu_only_ready", {31'b0, dbg_ready}, 32'd0);
    applyStimulus(idle());
    @(negedge clk);
    checkOutput("cpu_only_rdata", cpu_rdata, 32'hDEADBEEF);

    s = idle(); s.dbg_valid = 1'b1; s.dbg_we = 4'hF; s.dbg_addr = 16'h0020; s.dbg_wdata = 32'h12345678;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("dbg_wr_ready", {31'b0, dbg_ready}, 32'd1);
    s.dbg_we = 4'h0;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("dbg_rd_ready", {31'b0, dbg_ready}, 32'd1);
    applyStimulus(idle());
    @(negedge clk);
    checkOutput("dbg_rd_rvalid", {31'b0, dbg_rvalid}, 32'd1);
    checkOutput("dbg_rd_rdata", dbg_rdata, 32'h12345678);

    // Continuous contention: four denials, then one forced debug slot, repeating.
    for (int i = 0; i < 10; i++) begin
      s = idle(); s.cpu_req = 1'b1; s.cpu_addr = 16'h0010; s.dbg_valid = 1'b1; s.dbg_addr = 16'h0020;
      applyStimulus(s);
      @(negedge clk);
      checkOutput("starve_ready", {31'b0, dbg_ready}, (i % 5 == 4) ? 32'd1 : 32'd0);
      checkOutput("starve_stall", {31'b0, cpu_stall}, (i % 5 == 4) ? 32'd1 : 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      s = idle(); s.cpu_req = 1'b1;
      if (i == 0) s.cpu_addr = 16'h0010;
      else begin
        s.cpu_addr = 16'h0040; s.cpu_we = 4'b0001; s.cpu_wdata = 32'h000000A5;
      end
      s.dbg_lock = (i < 6);
      applyStimulus(s);
      @(negedge clk);
      checkOutput("lock_stall", {31'b0, cpu_stall}, (i >= 1 && i <= 6) ? 32'd1 : 32'd0);
      if (i == 6) checkOutput("lock_no_commit", dram[16'h0040], 32'h0);
    end
    s = idle(); s.cpu_req = 1'b1; s.cpu_addr = 16'h0040;
    applyStimulus(s);
    applyStimulus(idle());
    @(negedge clk);
    checkOutput("lock_store_rdata", cpu_rdata, 32'h000000A5);

    s = idle(); s.dbg_valid = 1'b1; s.dbg_we = 4'hF; s.dbg_addr = 16'h0030; s.dbg_wdata = 32'hFFFFFFFF;
    applyStimulus(s);
    s = idle(); s.cpu_req = 1'b1; s.cpu_we = 4'b0100; s.cpu_addr = 16'h0030; s.cpu_wdata = 32'h0;
    applyStimulus(s);
    s.cpu_we = 4'h0;
    applyStimulus(s);
    applyStimulus(idle());
    @(negedge clk);
    checkOutput("byte_strobe_rdata", cpu_rdata, 32'hFF00FFFF);

    // Reset one denial short of a forced slot must restart the count.
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.cpu_req = 1'b1; s.cpu_addr = 16'h0010; s.dbg_valid = 1'b1; s.dbg_addr = 16'h0020;
      s.rst_n = (i != 3);
      applyStimulus(s);
      @(negedge clk);
      checkOutput("reset_starve_ready", {31'b0, dbg_ready}, 32'd0);
    end
    applyStimulus(idle());
    s = idle(); s.dbg_valid = 1'b1; s.dbg_addr = 16'h0020; s.rst_n = 1'b0;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("reset_rd_ready", {31'b0, dbg_ready}, 32'd1);
    applyStimulus(idle());
    @(negedge clk);
    checkOutput("reset_rd_rvalid", {31'b0, dbg_rvalid}, 32'd0);

    lock_left = 0;
    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.rst_n = ($urandom_range(0, 99) != 0);
      s.cpu_req = ($urandom_range(0, 99) < 60);
      s.cpu_we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      s.cpu_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 63));
      s.cpu_wdata = $urandom;
      if (m_dbg_waiting && $urandom_range(0, 9) != 0) begin
        s.dbg_valid = 1'b1; s.dbg_we = m_last.dbg_we;
        s.dbg_addr = m_last.dbg_addr; s.dbg_wdata = m_last.dbg_wdata;
      end else begin
        s.dbg_valid = ($urandom_range(0, 99) < 50);
        s.dbg_we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        s.dbg_addr = AW'($urandom_range(0, 63));
        s.dbg_wdata = $urandom;
      end
      if (lock_left > 0) begin
        s.dbg_lock = 1'b1;
        lock_left--;
      end else if ($urandom_range(0, 39) == 0) begin
        s.dbg_lock = 1'b1;
        lock_left = $urandom_range(0, 5);
      end
      applyStimulus(s);
    end

    applyStimulus(idle());
    applyStimulus(idle());
    @(negedge clk);
    @(negedge clk);
    checkOutput("exp_q_drained", exp_q.size(), 32'd0);
    checkOutput("rd_q_drained", rd_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
